cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Completion stage directly downstream of the functional units. Captures each FU's result (T_idx, value, done) into a small per-FU buffer and arbitrates buffered results onto NUM_CDB common data bus slots with round-robin priority. Drives per-FU full_hazard back to the FUs, so the ALU and pipelined multiplier stall instead of dropping results.

Parameters:
NUM_FU, 4, number of FU result ports (ALUs plus multipliers)
NUM_CDB, 2, CDB broadcast slots per cycle
PR_IDX_W, 6, physical register tag width (T_idx)
DATA_W, 64, result width
BUF_DEPTH, 2, entries per FU result buffer (power of two, >=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash (rollback); drops all buffered and incoming results
fu_done  in  NUM_FU  FU i presents a completed result this cycle
fu_t_idx  in  NUM_FU*PR_IDX_W  destination tag per FU, slice i at [i*PR_IDX_W +: PR_IDX_W]
fu_result  in  NUM_FU*DATA_W  result value per FU, slice i at [i*DATA_W +: DATA_W]
full_hazard  out  NUM_FU  FU i must hold its output; fu_done[i] is ignored while high
cdb_valid  out  NUM_CDB  slot s carries a valid broadcast
cdb_t_idx  out  NUM_CDB*PR_IDX_W  broadcast tag per slot
cdb_result  out  NUM_CDB*DATA_W  broadcast value per slot

Behaviour:
- Reset (async, immediate): all buffers empty, rr_ptr=0, cdb_valid=0, cdb_t_idx=0, cdb_result=0, full_hazard=0.
- Per-FU FIFO, depth BUF_DEPTH, with count[i] and head/tail pointers that wrap modulo BUF_DEPTH.
- full_hazard[i] = (count[i]==BUF_DEPTH). Driven only from registers, with no combinational path from fu_done or from the grant logic.
- Push: fu_done[i] && !full_hazard[i] && !flush writes {t_idx,result} at tail on the clock edge.
- Arbitration (combinational, each cycle): scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU. Grant the first NUM_CDB FUs with count>0, at most one entry per FU per cycle. Slot 0 gets the first grant in scan order, slot 1 the next, and so on.
- Pop: a granted head is popped on the edge. Its entry loads into the CDB output register of its slot; that slot's cdb_valid=1. Ungranted slots load cdb_valid=0; their tag/result hold the previous value.
- Push and pop on the same FU in the same cycle: count unchanged, entries stay FIFO ordered. This is legal only when not full, since full_hazard blocks the push.
- rr_ptr update: (index of last granted FU + 1) mod NUM_FU; unchanged if nothing is granted.
- Latency (macro off): fu_done sampled at edge E0 (push). Earliest grant is in the cycle after E0, with the pop at edge E1, so cdb_valid is visible after E1. Minimum latency is 2 cycles from the done cycle.
- Ordering: results from one FU broadcast in arrival order. No result is lost or duplicated.
- Throughput: min(NUM_CDB, number of non-empty FUs) broadcasts per cycle.
- Flush: on the edge, all counts and pointers go to 0, rr_ptr=0, cdb_valid=0. fu_done in the flush cycle is dropped. full_hazard is low the following cycle. Reset dominates flush.
- Reset asserted mid-operation: buffered entries are discarded and outputs are cleared without waiting for a clock edge.

Optional Feature:
CDB_BYPASS_EN. When defined: if FU i has count[i]==0 and fu_done[i] is high, that result takes part in arbitration in the same cycle as a virtual head. If granted, it loads straight into the CDB register at E0 and is not pushed, giving 1-cycle latency. If not granted, it is pushed normally. Buffered heads and bypass candidates share the same round-robin scan. When undefined: all results pass through the buffer, with a minimum latency of 2.

Test Plan:
1. Single result: reset, then fu_done=4'b0001, T_idx=5, result=0x2A for 1 cycle. Expect 2 cycles later cdb_valid=2'b01, cdb_t_idx slot0=5, cdb_result slot0=0x2A. Valid for exactly 1 cycle.
2. Round-robin: all four FUs done in one cycle with tags 1..4 and rr_ptr=0. Expect the first broadcast cycle to show slots {1,2} and the next cycle slots {3,4}. rr_ptr returns to 0.
3. Back-pressure: all four FUs done every cycle for 8 cycles, each FU using ascending tags. Expect full_hazard to assert on some FUs. Every accepted tag is broadcast exactly once and in per-FU order. No tag offered while full_hazard was high is broadcast unless it is re-presented after deassert.
4. Flush: 3 entries buffered across FUs, pulse flush. Expect cdb_valid=0 next cycle and full_hazard=0. None of the 3 tags ever appears on the CDB.
5. Async reset mid-stream: assert reset between edges while cdb_valid=2'b11. Expect cdb_valid=0 and full_hazard=0 immediately, before any edge. After release, nothing is broadcast until a new fu_done.
6. With CDB_BYPASS_EN: repeat test 1. Expect the broadcast 1 cycle after the done cycle. With FU0 buffered and FU1 bypassing at rr_ptr=0, expect slot0=FU0 head and slot1=FU1 bypass in the same cycle.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Completion stage: per-FU result FIFOs arbitrated round-robin onto NUM_CDB broadcast slots.
// Optional macro CDB_BYPASS_EN lets a result arriving at an empty FU buffer go to the CDB in the same cycle.
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int NUM_CDB   = 2,
  parameter int PR_IDX_W  = 6,
  parameter int DATA_W    = 64,
  parameter int BUF_DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_FU-1:0]           fu_done,
  input  logic [NUM_FU*PR_IDX_W-1:0]  fu_t_idx,
  input  logic [NUM_FU*DATA_W-1:0]    fu_result,
  output logic [NUM_FU-1:0]           full_hazard,
  output logic [NUM_CDB-1:0]          cdb_valid,
  output logic [NUM_CDB*PR_IDX_W-1:0] cdb_t_idx,
  output logic [NUM_CDB*DATA_W-1:0]   cdb_result
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  logic [PR_IDX_W-1:0] tag_mem_q  [NUM_FU][BUF_DEPTH];
  logic [DATA_W-1:0]   data_mem_q [NUM_FU][BUF_DEPTH];
  logic [PTR_W-1:0]    head_q     [NUM_FU];
  logic [PTR_W-1:0]    tail_q     [NUM_FU];
  logic [CNT_W-1:0]    count_q    [NUM_FU];
  logic [RR_W-1:0]     rr_q, rr_d;
  logic [NUM_CDB-1:0]          cdb_valid_q, cdb_valid_d;
  logic [NUM_CDB*PR_IDX_W-1:0] cdb_t_idx_q, cdb_t_idx_d;
  logic [NUM_CDB*DATA_W-1:0]   cdb_result_q, cdb_result_d;

  logic [NUM_FU-1:0]   cand_s, grant_s, bypass_s, push_s, pop_s;
  logic [PR_IDX_W-1:0] head_tag_s  [NUM_FU];
  logic [DATA_W-1:0]   head_data_s [NUM_FU];
  logic [PR_IDX_W-1:0] slot_tag_s;
  logic [DATA_W-1:0]   slot_data_s;
  logic                sel_s;
  int                  pos_s  [NUM_FU];
  int                  rank_s [NUM_FU];
  int                  n_grant;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign cdb_valid  = cdb_valid_q;
  assign cdb_t_idx  = cdb_t_idx_q;
  assign cdb_result = cdb_result_q;

  // Head candidates: buffered head, or (bypass build) the incoming result of an empty FU.
  always_comb begin
    for (int j = 0; j < NUM_FU; j++) begin
      full_hazard[j] = (count_q[j] == FULL_CNT);
`ifdef CDB_BYPASS_EN
      bypass_s[j] = (count_q[j] == '0) && fu_done[j];
`else
      bypass_s[j] = 1'b0;
`endif
      cand_s[j]      = (count_q[j] != '0) | bypass_s[j];
      head_tag_s[j]  = bypass_s[j] ? fu_t_idx[j*PR_IDX_W +: PR_IDX_W] : tag_mem_q[j][head_q[j]];
      head_data_s[j] = bypass_s[j] ? fu_result[j*DATA_W +: DATA_W] : data_mem_q[j][head_q[j]];
    end
  end

  // Round-robin: rank = number of candidates ahead in scan order starting at rr_q.
  always_comb begin
    n_grant = 0;
    rr_d    = rr_q;
    for (int j = 0; j < NUM_FU; j++) begin
      pos_s[j] = (j + NUM_FU - int'(rr_q)) % NUM_FU;
    end
    for (int j = 0; j < NUM_FU; j++) begin
      rank_s[j] = 0;
      for (int m = 0; m < NUM_FU; m++) begin
        rank_s[j] = rank_s[j] + ((cand_s[m] && (pos_s[m] < pos_s[j])) ? 1 : 0);
      end
      grant_s[j] = cand_s[j] && (rank_s[j] < NUM_CDB);
      n_grant    = n_grant + (grant_s[j] ? 1 : 0);
    end
    for (int j = 0; j < NUM_FU; j++) begin
      rr_d = (grant_s[j] && (rank_s[j] == n_grant - 1)) ? RR_W'((j + 1) % NUM_FU) : rr_d;
    end
  end

  // Slot s takes the FU whose rank is s; unused slots keep their last tag/result.
  always_comb begin
    cdb_valid_d  = '0;
    cdb_t_idx_d  = cdb_t_idx_q;
    cdb_result_d = cdb_result_q;
    slot_tag_s   = '0;
    slot_data_s  = '0;
    sel_s        = 1'b0;
    for (int s = 0; s < NUM_CDB; s++) begin
      slot_tag_s  = '0;
      slot_data_s = '0;
      for (int j = 0; j < NUM_FU; j++) begin
        sel_s          = grant_s[j] && (rank_s[j] == s);
        cdb_valid_d[s] = cdb_valid_d[s] | sel_s;
        slot_tag_s     = slot_tag_s | ({PR_IDX_W{sel_s}} & head_tag_s[j]);
        slot_data_s    = slot_data_s | ({DATA_W{sel_s}} & head_data_s[j]);
      end
      cdb_t_idx_d[s*PR_IDX_W +: PR_IDX_W] = cdb_valid_d[s] ? slot_tag_s : cdb_t_idx_q[s*PR_IDX_W +: PR_IDX_W];
      cdb_result_d[s*DATA_W +: DATA_W]    = cdb_valid_d[s] ? slot_data_s : cdb_result_q[s*DATA_W +: DATA_W];
    end
  end

  // A bypassed result is consumed directly and never enters the buffer.
  always_comb begin
    for (int j = 0; j < NUM_FU; j++) begin
      push_s[j] = fu_done[j] && !full_hazard[j] && !flush && !(grant_s[j] && bypass_s[j]);
      pop_s[j]  = grant_s[j] && !bypass_s[j];
    end
  end

  // Buffer state, round-robin pointer and CDB output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NUM_FU; j++) begin
        head_q[j]  <= '0;
        tail_q[j]  <= '0;
        count_q[j] <= '0;
        for (int e = 0; e < BUF_DEPTH; e++) begin
          tag_mem_q[j][e]  <= '0;
          data_mem_q[j][e] <= '0;
        end
      end
      rr_q         <= '0;
      cdb_valid_q  <= '0;
      cdb_t_idx_q  <= '0;
      cdb_result_q <= '0;
    end else if (flush) begin
      for (int j = 0; j < NUM_FU; j++) begin
        head_q[j]  <= '0;
        tail_q[j]  <= '0;
        count_q[j] <= '0;
      end
      rr_q        <= '0;
      cdb_valid_q <= '0;
    end else begin
      for (int j = 0; j < NUM_FU; j++) begin
        if (push_s[j]) begin
          tag_mem_q[j][tail_q[j]]  <= fu_t_idx[j*PR_IDX_W +: PR_IDX_W];
          data_mem_q[j][tail_q[j]] <= fu_result[j*DATA_W +: DATA_W];
          tail_q[j]                <= ptr_inc(tail_q[j]);
        end
        if (pop_s[j]) begin
          head_q[j] <= ptr_inc(head_q[j]);
        end
        case ({push_s[j], pop_s[j]})
          2'b10:   count_q[j] <= count_q[j] + CNT_W'(1);
          2'b01:   count_q[j] <= count_q[j] - CNT_W'(1);
          default: count_q[j] <= count_q[j];
        endcase
      end
      rr_q         <= rr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_t_idx_q  <= cdb_t_idx_d;
      cdb_result_q <= cdb_result_d;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, hand sequences, and a
// randomized run against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int NFU = 4;
  localparam int NCDB = 2;
  localparam int TW = 6;
  localparam int DW = 64;
  localparam int DEPTH = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic [NFU-1:0]    fu_done = '0;
  logic [NFU*TW-1:0] fu_t_idx = '0;
  logic [NFU*DW-1:0] fu_result = '0;
  logic [NFU-1:0]    full_hazard;
  logic [NCDB-1:0]   cdb_valid;
  logic [NCDB*TW-1:0] cdb_t_idx;
  logic [NCDB*DW-1:0] cdb_result;

  int checks = 0;
  int failures = 0;

  cdb_arbiter #(.NUM_FU(NFU), .NUM_CDB(NCDB), .PR_IDX_W(TW), .DATA_W(DW), .BUF_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush), .fu_done(fu_done), .fu_t_idx(fu_t_idx),
    .fu_result(fu_result), .full_hazard(full_hazard), .cdb_valid(cdb_valid),
    .cdb_t_idx(cdb_t_idx), .cdb_result(cdb_result));

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] res_of(input logic [5:0] t);
    return (t == 6'd5) ? 64'h2A : (64'hFEED_0000_0000_0000 + {58'd0, t});
  endfunction

  task automatic put(input int i, input logic [5:0] t, input logic [63:0] r);
    fu_t_idx[i*TW +: TW] = t;
    fu_result[i*DW +: DW] = r;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clock);
    fu_done = '0;
    flush = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic chk_slot(input string name, input int s, input logic [5:0] t, input logic [63:0] r);
    chk({name, "_tag"}, 64'(cdb_t_idx[s*TW +: TW]), 64'(t));
    chk({name, "_res"}, cdb_result[s*DW +: DW], r);
  endtask

  typedef struct packed {
    logic [3:0]      done;
    logic [3:0][5:0] tag;
    logic [1:0]      ev;
    logic [1:0][5:0] et;
    logic [3:0]      efull;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] d, input logic [5:0] t3, t2, t1, t0,
                              input logic [1:0] ev, input logic [5:0] e1, e0, input logic [3:0] f);
    vec_t v;
    v.done = d;
    v.tag = {t3, t2, t1, t0};
    v.ev = ev;
    v.et = {e1, e0};
    v.efull = f;
    return v;
  endfunction

  // Reference model: one queue per FU, round-robin pointer as a plain integer.
  typedef struct packed { logic [5:0] t; logic [63:0] d; } ent_t;
  ent_t        mq [NFU][$];
  int          m_rr;
  logic [1:0]  e_valid;
  logic [5:0]  e_tag [NCDB];
  logic [63:0] e_res [NCDB];
  logic [3:0]  e_full;

  task automatic model_clear();
    for (int i = 0; i < NFU; i++) mq[i].delete();
    m_rr = 0;
    e_valid = '0;
    e_full = '0;
  endtask

  task automatic model_step();
    int n;
    int last;
    int pre [NFU];
    logic [3:0] took;
    ent_t ent;
    if (flush) begin
      model_clear();
      return;
    end
    n = 0;
    last = -1;
    took = '0;
    e_valid = '0;
    for (int i = 0; i < NFU; i++) pre[i] = mq[i].size();
    for (int k = 0; k < NFU; k++) begin
      int i;
      i = (m_rr + k) % NFU;
      if (n < NCDB) begin
        if (mq[i].size() > 0) begin
          ent = mq[i].pop_front();
          e_tag[n] = ent.t;
          e_res[n] = ent.d;
          e_valid[n] = 1'b1;
          n++;
          last = i;
        end
`ifdef CDB_BYPASS_EN
        else if (fu_done[i]) begin
          e_tag[n] = fu_t_idx[i*TW +: TW];
          e_res[n] = fu_result[i*DW +: DW];
          e_valid[n] = 1'b1;
          took[i] = 1'b1;
          n++;
          last = i;
        end
`endif
      end
    end
    for (int i = 0; i < NFU; i++) begin
      if (fu_done[i] && !took[i] && pre[i] < DEPTH) begin
        ent.t = fu_t_idx[i*TW +: TW];
        ent.d = fu_result[i*DW +: DW];
        mq[i].push_back(ent);
      end
    end
    if (last >= 0) m_rr = (last + 1) % NFU;
    for (int i = 0; i < NFU; i++) e_full[i] = (mq[i].size() == DEPTH);
  endtask

  vec_t tbl [18];

  initial begin
    tbl[0]  = mk(4'b0001, 0, 0, 0, 5, 2'b00, 0, 0, 4'b0000);
    tbl[1]  = mk(4'b0000, 0, 0, 0, 0, 2'b01, 0, 5, 4'b0000);
    tbl[2]  = mk(4'b1000, 9, 0, 0, 0, 2'b00, 0, 0, 4'b0000);
    tbl[3]  = mk(4'b0000, 0, 0, 0, 0, 2'b01, 0, 9, 4'b0000);
    tbl[4]  = mk(4'b1111, 4, 3, 2, 1, 2'b00, 0, 0, 4'b0000);
    tbl[5]  = mk(4'b0000, 0, 0, 0, 0, 2'b11, 2, 1, 4'b0000);
    tbl[6]  = mk(4'b0000, 0, 0, 0, 0, 2'b11, 4, 3, 4'b0000);
    tbl[7]  = mk(4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000);
    tbl[8]  = mk(4'b1001, 8, 0, 0, 6, 2'b00, 0, 0, 4'b0000);
    tbl[9]  = mk(4'b0000, 0, 0, 0, 0, 2'b11, 8, 6, 4'b0000);
    tbl[10] = mk(4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000);
    tbl[11] = mk(4'b1111, 14, 13, 12, 11, 2'b00, 0, 0, 4'b0000);
    tbl[12] = mk(4'b1111, 24, 23, 22, 21, 2'b11, 12, 11, 4'b1100);
    tbl[13] = mk(4'b1111, 34, 33, 32, 31, 2'b11, 14, 13, 4'b0011);
    tbl[14] = mk(4'b0000, 0, 0, 0, 0, 2'b11, 22, 21, 4'b0000);
    tbl[15] = mk(4'b0000, 0, 0, 0, 0, 2'b11, 24, 23, 4'b0000);
    tbl[16] = mk(4'b0000, 0, 0, 0, 0, 2'b11, 32, 31, 4'b0000);
    tbl[17] = mk(4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0000);

    #12;
    chk("reset_valid", 64'(cdb_valid), 64'd0);
    chk("reset_full", 64'(full_hazard), 64'd0);
    chk("reset_tag", 64'(cdb_t_idx), 64'd0);
    chk("reset_res", cdb_result[63:0] | cdb_result[127:64], 64'd0);
    @(negedge clock);
    reset = 1'b0;

`ifndef CDB_BYPASS_EN
    for (int k = 0; k < 18; k++) begin
      fu_done = tbl[k].done;
      for (int i = 0; i < NFU; i++) put(i, tbl[k].tag[i], res_of(tbl[k].tag[i]));
      step();
      chk($sformatf("tbl%0d_valid", k), 64'(cdb_valid), 64'(tbl[k].ev));
      chk($sformatf("tbl%0d_full", k), 64'(full_hazard), 64'(tbl[k].efull));
      for (int s = 0; s < NCDB; s++)
        if (tbl[k].ev[s]) chk_slot($sformatf("tbl%0d_s%0d", k, s), s, tbl[k].et[s], res_of(tbl[k].et[s]));
    end

    // Flush with buffered entries (rr starts at 2 here).
    fu_done = 4'b1111;
    for (int i = 0; i < NFU; i++) put(i, 6'(40 + i), res_of(6'(40 + i)));
    step();
    for (int i = 0; i < NFU; i++) put(i, 6'(50 + i), res_of(6'(50 + i)));
    step();
    chk("pre_flush_valid", 64'(cdb_valid), 64'd3);
    chk("pre_flush_full", 64'(full_hazard), 64'h3);
    chk_slot("pre_flush_s0", 0, 6'd42, res_of(6'd42));
    chk_slot("pre_flush_s1", 1, 6'd43, res_of(6'd43));
    flush = 1'b1;
    for (int i = 0; i < NFU; i++) put(i, 6'(60 + i), res_of(6'(60 + i)));
    step();
    flush = 1'b0;
    fu_done = '0;
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    chk("flush_full", 64'(full_hazard), 64'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("flush_quiet%0d", c), 64'(cdb_valid), 64'd0);
    end
    fu_done = 4'b1001;
    put(0, 6'd7, res_of(6'd7));
    put(3, 6'd8, res_of(6'd8));
    step();
    fu_done = '0;
    step();
    chk("flush_rr_valid", 64'(cdb_valid), 64'd3);
    chk_slot("flush_rr_s0", 0, 6'd7, res_of(6'd7));
    chk_slot("flush_rr_s1", 1, 6'd8, res_of(6'd8));

    // Asynchronous reset between edges while both slots are valid.
    fu_done = 4'b1111;
    for (int i = 0; i < NFU; i++) put(i, 6'(10 + i), res_of(6'(10 + i)));
    step();
    for (int i = 0; i < NFU; i++) put(i, 6'(20 + i), res_of(6'(20 + i)));
    step();
    fu_done = '0;
    chk("pre_rst_valid", 64'(cdb_valid), 64'd3);
    chk("pre_rst_full", 64'(full_hazard), 64'hC);
    chk_slot("pre_rst_s0", 0, 6'd10, res_of(6'd10));
    #3;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(cdb_valid), 64'd0);
    chk("arst_full", 64'(full_hazard), 64'd0);
    chk("arst_tag", 64'(cdb_t_idx), 64'd0);
    step();
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("arst_quiet%0d", c), 64'(cdb_valid), 64'd0);
    end
    fu_done = 4'b1001;
    put(0, 6'd30, res_of(6'd30));
    put(3, 6'd31, res_of(6'd31));
    step();
    fu_done = '0;
    step();
    chk("arst_rr_valid", 64'(cdb_valid), 64'd3);
    chk_slot("arst_rr_s0", 0, 6'd30, res_of(6'd30));
    chk_slot("arst_rr_s1", 1, 6'd31, res_of(6'd31));
`else
    fu_done = 4'b0001;
    put(0, 6'd5, 64'h2A);
    step();
    fu_done = '0;
    chk("byp_valid", 64'(cdb_valid), 64'd1);
    chk_slot("byp_s0", 0, 6'd5, 64'h2A);
    step();
    chk("byp_once", 64'(cdb_valid), 64'd0);
    reset_dut();
    fu_done = 4'b1111;
    for (int i = 0; i < NFU; i++) put(i, 6'(1 + i), res_of(6'(1 + i)));
    step();
    chk("byp_a_valid", 64'(cdb_valid), 64'd3);
    chk_slot("byp_a_s0", 0, 6'd1, res_of(6'd1));
    chk_slot("byp_a_s1", 1, 6'd2, res_of(6'd2));
    fu_done = 4'b0001;
    put(0, 6'd6, res_of(6'd6));
    step();
    chk_slot("byp_b_s0", 0, 6'd3, res_of(6'd3));
    chk_slot("byp_b_s1", 1, 6'd4, res_of(6'd4));
    fu_done = 4'b0010;
    put(1, 6'd7, res_of(6'd7));
    step();
    fu_done = '0;
    chk("byp_mix_valid", 64'(cdb_valid), 64'd3);
    chk_slot("byp_mix_s0", 0, 6'd6, res_of(6'd6));
    chk_slot("byp_mix_s1", 1, 6'd7, res_of(6'd7));
`endif

    // Randomized run against the reference model; first 8 cycles saturate all FUs.
    reset_dut();
    model_clear();
    for (int s = 0; s < NCDB; s++) begin
      e_tag[s] = '0;
      e_res[s] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      if (c < 8) begin
        fu_done = 4'b1111;
        flush = 1'b0;
        for (int i = 0; i < NFU; i++) put(i, 6'(c * 4 + i), {$urandom, $urandom});
      end else begin
        fu_done = 4'($urandom);
        flush = ($urandom_range(0, 31) == 0);
        for (int i = 0; i < NFU; i++) put(i, 6'($urandom), {$urandom, $urandom});
      end
      model_step();
      step();
      chk("rnd_valid", 64'(cdb_valid), 64'(e_valid));
      chk("rnd_full", 64'(full_hazard), 64'(e_full));
      for (int s = 0; s < NCDB; s++)
        if (e_valid[s]) chk_slot($sformatf("rnd_s%0d", s), s, e_tag[s], e_res[s]);
    end
    fu_done = '0;
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
